// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants
package mips_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam int JUMP_INDEX_W = 26;
endpackage

// File: rtl/if_pc_fetch_unit.sv
// if_pc_fetch_unit: IF-stage PC owner with redirect, stall, flush and sticky fetch-fault trap
module if_pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PCWrite,
  input  logic                    IF_IDWrite,
  input  logic                    branch_taken,
  input  logic [ADDR_SIZE-1:0]    branch_target,
  input  logic                    jump,
  input  logic [JUMP_INDEX_W-1:0] jump_index,
  output logic [ADDR_SIZE-1:0]    read_address,
  output logic                    IF_Flush,
  output logic [ADDR_SIZE-1:0]    if_id_pc_plus4,
  output logic                    if_id_valid,
  output logic                    fetch_fault,
  output logic [ADDR_SIZE-1:0]    fault_pc
);
  localparam logic [ADDR_SIZE-1:0] LP_LAST_PC = ADDR_SIZE'(MEM_DEPTH - INSTR_BYTES);

  fetch_state_t           r_state, w_next_state;
  logic [ADDR_SIZE-1:0]   r_pc, w_next_pc, w_pc_plus4, w_jump_pc;
  logic [ADDR_SIZE-1:0]   r_if_id_pc_plus4, r_fault_pc;
  logic                   r_if_id_valid, r_fetch_fault;
  logic                   w_bad, w_flush;

  assign w_pc_plus4 = r_pc + ADDR_SIZE'(INSTR_BYTES);
  assign w_jump_pc  = {r_if_id_pc_plus4[ADDR_SIZE-1 -: 4], jump_index, 2'b00};
  assign w_bad      = (r_pc[1:0] != 2'b00) || (r_pc > LP_LAST_PC);

  // Next state, next PC and flush; a bad PC beats any redirect or stall
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_flush      = 1'b0;
    case (r_state)
      BOOT: begin
        w_flush      = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        if (w_bad) begin
          w_flush      = 1'b1;
          w_next_state = FAULT;
        end else if (PCWrite) begin
          w_flush   = branch_taken || jump;
          w_next_pc = branch_taken ? branch_target : jump ? w_jump_pc : w_pc_plus4;
        end
      end
      default: w_flush = 1'b1;
    endcase
  end

  // PC, IF/ID and fault registers; flush clears IF/ID even while IF_IDWrite is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= BOOT;
      r_pc             <= RESET_VECTOR;
      r_if_id_pc_plus4 <= '0;
      r_if_id_valid    <= 1'b0;
      r_fetch_fault    <= 1'b0;
      r_fault_pc       <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_flush) begin
        r_if_id_pc_plus4 <= '0;
        r_if_id_valid    <= 1'b0;
      end else if (IF_IDWrite) begin
        r_if_id_pc_plus4 <= w_pc_plus4;
        r_if_id_valid    <= 1'b1;
      end
      if (r_state == RUN && w_bad) begin
        r_fetch_fault <= 1'b1;
        r_fault_pc    <= r_pc;
      end
    end
  end

  assign read_address   = r_pc;
  assign IF_Flush       = w_flush;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_valid    = r_if_id_valid;
  assign fetch_fault    = r_fetch_fault;
  assign fault_pc       = r_fault_pc;
endmodule

// File: tb/tb_if_pc_fetch_unit.sv
// tb_if_pc_fetch_unit: directed scoreboard bench for the IF fetch controller
module tb_if_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1, IF_IDWrite = 1'b1;
  logic        branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] read_address, if_id_pc_plus4, fault_pc;
  logic        IF_Flush, if_id_valid, fetch_fault;

  typedef struct {
    string       nm;
    logic [31:0] ra;
    logic        fl;
    logic [31:0] pc4;
    logic        v;
    logic        f;
    logic [31:0] fpc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  if_pc_fetch_unit #(.ADDR_SIZE(32), .MEM_DEPTH(1024), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .read_address(read_address), .IF_Flush(IF_Flush),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (read_address !== e.ra || IF_Flush !== e.fl || if_id_pc_plus4 !== e.pc4 ||
          if_id_valid !== e.v || fetch_fault !== e.f || fault_pc !== e.fpc) begin
        n_err++;
        $display("FAIL %s: got ra=%h fl=%b pc4=%h v=%b f=%b fpc=%h, want ra=%h fl=%b pc4=%h v=%b f=%b fpc=%h",
                 e.nm, read_address, IF_Flush, if_id_pc_plus4, if_id_valid, fetch_fault, fault_pc,
                 e.ra, e.fl, e.pc4, e.v, e.f, e.fpc);
      end
    end
  end

  task automatic cyc(input string nm, input logic rn, pw, iw, bt, input logic [31:0] tg,
                     input logic j, input logic [25:0] ji,
                     input logic [31:0] era, input logic efl, input logic [31:0] epc4,
                     input logic ev, ef, input logic [31:0] efp);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; PCWrite = pw; IF_IDWrite = iw;
    branch_taken = bt; branch_target = tg; jump = j; jump_index = ji;
    e.nm = nm; e.ra = era; e.fl = efl; e.pc4 = epc4; e.v = ev; e.f = ef; e.fpc = efp;
    q.push_back(e);
  endtask

  initial begin
    //   name          rn pw iw bt target     j  idx     | ra         fl pc4        v  f  fault_pc
    cyc("reset",      0, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     1, 32'h0,     0, 0, 32'h0);
    cyc("boot",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     1, 32'h0,     0, 0, 32'h0);
    cyc("run0",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     0, 32'h0,     0, 0, 32'h0);
    cyc("seq4",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h4,     0, 32'h4,     1, 0, 32'h0);
    cyc("seq8",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h8,     0, 32'h8,     1, 0, 32'h0);
    cyc("seqc",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'hc,     0, 32'hc,     1, 0, 32'h0);
    cyc("stall1",     1, 0, 0, 0, 32'h0,     0, 26'h0,  32'h10,    0, 32'h10,    1, 0, 32'h0);
    cyc("stall2",     1, 0, 0, 0, 32'h0,     0, 26'h0,  32'h10,    0, 32'h10,    1, 0, 32'h0);
    cyc("resume",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h10,    0, 32'h10,    1, 0, 32'h0);
    cyc("seq14",      1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h14,    0, 32'h14,    1, 0, 32'h0);
    cyc("seq18",      1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h18,    0, 32'h18,    1, 0, 32'h0);
    cyc("seq1c",      1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h1c,    0, 32'h1c,    1, 0, 32'h0);
    cyc("br_and_j",   1, 1, 1, 1, 32'h100,   1, 26'h3,  32'h20,    1, 32'h20,    1, 0, 32'h0);
    cyc("br_land",    1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h100,   0, 32'h0,     0, 0, 32'h0);
    cyc("j_stalled",  1, 0, 0, 0, 32'h0,     1, 26'h40, 32'h104,   0, 32'h104,   1, 0, 32'h0);
    cyc("jump",       1, 1, 1, 0, 32'h0,     1, 26'h40, 32'h104,   1, 32'h104,   1, 0, 32'h0);
    cyc("j_land",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h100,   0, 32'h0,     0, 0, 32'h0);
    cyc("br_3fc",     1, 1, 1, 1, 32'h3fc,   0, 26'h0,  32'h104,   1, 32'h104,   1, 0, 32'h0);
    cyc("at_3fc",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h3fc,   0, 32'h0,     0, 0, 32'h0);
    cyc("at_400",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h400,   1, 32'h400,   1, 0, 32'h0);
    cyc("fault_400",  1, 1, 1, 1, 32'h40,    0, 26'h0,  32'h400,   1, 32'h0,     0, 1, 32'h400);
    cyc("frozen",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h400,   1, 32'h0,     0, 1, 32'h400);
    cyc("rst_fault",  0, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     1, 32'h0,     0, 0, 32'h0);
    cyc("boot2",      1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     1, 32'h0,     0, 0, 32'h0);
    cyc("run2",       1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h0,     0, 32'h0,     0, 0, 32'h0);
    cyc("br_3fe",     1, 1, 1, 1, 32'h3fe,   0, 26'h0,  32'h4,     1, 32'h4,     1, 0, 32'h0);
    cyc("at_3fe",     1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h3fe,   1, 32'h0,     0, 0, 32'h0);
    cyc("fault_3fe",  1, 1, 1, 0, 32'h0,     0, 26'h0,  32'h3fe,   1, 32'h0,     0, 1, 32'h3fe);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
